// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, ALU/WB encodings, skid-buffer states.
package pipe_pkg;

    localparam int unsigned XLEN_DFLT      = 32;
    localparam int unsigned ALUCTRL_W_DFLT = 4;
    localparam int unsigned WBSEL_W_DFLT   = 2;
    localparam int unsigned REG_ADDR_W     = 5;

    // ALU operation encodings carried in the cu_ALUctrl field
    localparam logic [ALUCTRL_W_DFLT-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUCTRL_W_DFLT-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALUCTRL_W_DFLT-1:0] ALU_AND  = 4'd2;
    localparam logic [ALUCTRL_W_DFLT-1:0] ALU_OR   = 4'd3;
    localparam logic [ALUCTRL_W_DFLT-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALUCTRL_W_DFLT-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALUCTRL_W_DFLT-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALUCTRL_W_DFLT-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALUCTRL_W_DFLT-1:0] ALU_SLT  = 4'd8;
    localparam logic [ALUCTRL_W_DFLT-1:0] ALU_SLTU = 4'd9;

    // Writeback source select encodings
    localparam logic [WBSEL_W_DFLT-1:0] WB_ALU = 2'd0;
    localparam logic [WBSEL_W_DFLT-1:0] WB_MEM = 2'd1;
    localparam logic [WBSEL_W_DFLT-1:0] WB_PC4 = 2'd2;

    // Occupancy of a 2-entry skid register
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/id_ex_reg_if.sv
// ID/EX boundary bundle: decode-side inputs, EX-side outputs, handshake and flush.
interface id_ex_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DFLT,
    parameter int unsigned ALUCTRL_W = ALUCTRL_W_DFLT,
    parameter int unsigned WBSEL_W   = WBSEL_W_DFLT
);

    logic                  flush_i;

    logic                  id_valid_i;
    logic                  id_ready_o;
    logic [XLEN-1:0]       id_pc_i;
    logic [XLEN-1:0]       id_rs1_data_i;
    logic [XLEN-1:0]       id_rs2_data_i;
    logic [XLEN-1:0]       id_imm_i;
    logic [REG_ADDR_W-1:0] id_rs1_addr_i;
    logic [REG_ADDR_W-1:0] id_rs2_addr_i;
    logic [REG_ADDR_W-1:0] id_rd_addr_i;
    logic [ALUCTRL_W-1:0]  cu_ALUctrl_i;
    logic                  cu_alu_src_i;
    logic                  cu_reg_we_i;
    logic                  cu_mem_re_i;
    logic                  cu_mem_we_i;
    logic [WBSEL_W-1:0]    cu_wb_sel_i;

    logic                  ex_valid_o;
    logic                  ex_ready_i;
    logic [XLEN-1:0]       ex_pc_o;
    logic [XLEN-1:0]       ex_rs1_data_o;
    logic [XLEN-1:0]       ex_rs2_data_o;
    logic [XLEN-1:0]       ex_imm_o;
    logic [REG_ADDR_W-1:0] ex_rs1_addr_o;
    logic [REG_ADDR_W-1:0] ex_rs2_addr_o;
    logic [REG_ADDR_W-1:0] ex_rd_addr_o;
    logic [ALUCTRL_W-1:0]  ex_ALUctrl_o;
    logic                  ex_alu_src_o;
    logic                  ex_reg_we_o;
    logic                  ex_mem_re_o;
    logic                  ex_mem_we_o;
    logic [WBSEL_W-1:0]    ex_wb_sel_o;

    // Surrounding pipeline: drives decode fields, EX ready and flush
    modport master (
        output flush_i,
        output id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
        output id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
        output cu_ALUctrl_i, cu_alu_src_i, cu_reg_we_i, cu_mem_re_i, cu_mem_we_i, cu_wb_sel_i,
        output ex_ready_i,
        input  id_ready_o,
        input  ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
        input  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
        input  ex_ALUctrl_o, ex_alu_src_o, ex_reg_we_o, ex_mem_re_o, ex_mem_we_o, ex_wb_sel_o
    );

    // The pipeline register itself
    modport slave (
        input  flush_i,
        input  id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
        input  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
        input  cu_ALUctrl_i, cu_alu_src_i, cu_reg_we_i, cu_mem_re_i, cu_mem_we_i, cu_wb_sel_i,
        input  ex_ready_i,
        output id_ready_o,
        output ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
        output ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
        output ex_ALUctrl_o, ex_alu_src_o, ex_reg_we_o, ex_mem_re_o, ex_mem_we_o, ex_wb_sel_o
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid register: registered upstream ready, flush, sync active-high reset.
// Entries that become invalid are cleared to zero so a bubble never carries stale data.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic             ready_q;
    logic             valid_q;
    logic             accept;
    logic             consume;

    assign accept    = in_valid & ready_q;
    assign consume   = valid_q & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = main_q;

    // State, entries and registered handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != ST_SKID);
            valid_q <= (state_d != ST_EMPTY);
        end
    end

    // Next occupancy and entry contents; flush overrides everything
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_FULL;
                        main_d  = in_data;
                    end
                end
                ST_FULL: begin
                    if (accept && consume) begin
                        main_d = in_data;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                        main_d  = '0;
                    end else if (accept) begin
                        state_d = ST_SKID;
                        skid_d  = in_data;
                    end
                end
                ST_SKID: begin
                    if (consume) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: packs decode operands and control word into a skid register.
module id_ex_reg
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DFLT,
    parameter int unsigned ALUCTRL_W = ALUCTRL_W_DFLT,
    parameter int unsigned WBSEL_W   = WBSEL_W_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    id_ex_reg_if.slave  bus
);

    localparam int unsigned PAYLOAD_W = 4*XLEN + 3*REG_ADDR_W + ALUCTRL_W + WBSEL_W + 4;

    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;

    // Side-effect enables are zeroed unless the instruction is valid, so bubbles stay inert
    assign in_payload = {
        bus.id_pc_i,
        bus.id_rs1_data_i,
        bus.id_rs2_data_i,
        bus.id_imm_i,
        bus.id_rs1_addr_i,
        bus.id_rs2_addr_i,
        bus.id_rd_addr_i,
        bus.cu_ALUctrl_i,
        bus.cu_alu_src_i,
        bus.cu_reg_we_i & bus.id_valid_i,
        bus.cu_mem_re_i & bus.id_valid_i,
        bus.cu_mem_we_i & bus.id_valid_i,
        bus.cu_wb_sel_i
    };

    pipe_skid_buf #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush_i),
        .in_valid  (bus.id_valid_i),
        .in_ready  (bus.id_ready_o),
        .in_data   (in_payload),
        .out_valid (bus.ex_valid_o),
        .out_ready (bus.ex_ready_i),
        .out_data  (out_payload)
    );

    // Unpack the held entry onto the EX-facing fields
    assign {
        bus.ex_pc_o,
        bus.ex_rs1_data_o,
        bus.ex_rs2_data_o,
        bus.ex_imm_o,
        bus.ex_rs1_addr_o,
        bus.ex_rs2_addr_o,
        bus.ex_rd_addr_o,
        bus.ex_ALUctrl_o,
        bus.ex_alu_src_o,
        bus.ex_reg_we_o,
        bus.ex_mem_re_o,
        bus.ex_mem_we_o,
        bus.ex_wb_sel_o
    } = out_payload;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg.
module tb_id_ex_reg;
    import pipe_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    id_ex_reg_if #(.XLEN(32), .ALUCTRL_W(4), .WBSEL_W(2)) bus ();

    id_ex_reg #(.XLEN(32), .ALUCTRL_W(4), .WBSEL_W(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        bus.id_valid_i = v;
        bus.id_pc_i    = pc;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        bus.flush_i       = 1'b0;
        bus.id_valid_i    = 1'b0;
        bus.id_pc_i       = '0;
        bus.id_rs1_data_i = '0;
        bus.id_rs2_data_i = '0;
        bus.id_imm_i      = '0;
        bus.id_rs1_addr_i = '0;
        bus.id_rs2_addr_i = '0;
        bus.id_rd_addr_i  = '0;
        bus.cu_ALUctrl_i  = '0;
        bus.cu_alu_src_i  = 1'b0;
        bus.cu_reg_we_i   = 1'b0;
        bus.cu_mem_re_i   = 1'b0;
        bus.cu_mem_we_i   = 1'b0;
        bus.cu_wb_sel_i   = '0;
        bus.ex_ready_i    = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ex_valid", 32'(bus.ex_valid_o), 32'd0);
        chk("rst_id_ready", 32'(bus.id_ready_o), 32'd1);
        chk("rst_ex_pc",    bus.ex_pc_o,         32'd0);
        chk("rst_reg_we",   32'(bus.ex_reg_we_o), 32'd0);

        // Single instruction with every field distinct
        drive(1'b1, 32'h0000_0010);
        bus.id_rs1_data_i = 32'hAAAA_0001;
        bus.id_rs2_data_i = 32'h5555_0002;
        bus.id_imm_i      = 32'hFFFF_FFF0;
        bus.id_rs1_addr_i = 5'd3;
        bus.id_rs2_addr_i = 5'd7;
        bus.id_rd_addr_i  = 5'd5;
        bus.cu_ALUctrl_i  = ALU_SUB;
        bus.cu_alu_src_i  = 1'b1;
        bus.cu_reg_we_i   = 1'b1;
        bus.cu_mem_re_i   = 1'b1;
        bus.cu_mem_we_i   = 1'b0;
        bus.cu_wb_sel_i   = WB_MEM;
        bus.ex_ready_i    = 1'b1;
        tick();
        drive(1'b0, 32'h0);
        chk("t1_ex_valid", 32'(bus.ex_valid_o),    32'd1);
        chk("t1_id_ready", 32'(bus.id_ready_o),    32'd1);
        chk("t1_pc",       bus.ex_pc_o,            32'h10);
        chk("t1_rs1_data", bus.ex_rs1_data_o,      32'hAAAA_0001);
        chk("t1_rs2_data", bus.ex_rs2_data_o,      32'h5555_0002);
        chk("t1_imm",      bus.ex_imm_o,           32'hFFFF_FFF0);
        chk("t1_rs1_addr", 32'(bus.ex_rs1_addr_o), 32'd3);
        chk("t1_rs2_addr", 32'(bus.ex_rs2_addr_o), 32'd7);
        chk("t1_rd_addr",  32'(bus.ex_rd_addr_o),  32'd5);
        chk("t1_aluctrl",  32'(bus.ex_ALUctrl_o),  32'd1);
        chk("t1_alu_src",  32'(bus.ex_alu_src_o),  32'd1);
        chk("t1_reg_we",   32'(bus.ex_reg_we_o),   32'd1);
        chk("t1_mem_re",   32'(bus.ex_mem_re_o),   32'd1);
        chk("t1_mem_we",   32'(bus.ex_mem_we_o),   32'd0);
        chk("t1_wb_sel",   32'(bus.ex_wb_sel_o),   32'd1);
        tick();
        chk("t1_drain_valid",  32'(bus.ex_valid_o),  32'd0);
        chk("t1_drain_reg_we", 32'(bus.ex_reg_we_o), 32'd0);
        chk("t1_drain_mem_re", 32'(bus.ex_mem_re_o), 32'd0);

        // Back-to-back stream, no bubbles
        bus.cu_mem_re_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4*i));
            tick();
            chk("stream_valid", 32'(bus.ex_valid_o), 32'd1);
            chk("stream_ready", 32'(bus.id_ready_o), 32'd1);
            chk("stream_pc",    bus.ex_pc_o,         32'(4*i));
        end
        drive(1'b0, 32'h0);
        tick();
        chk("stream_end_valid", 32'(bus.ex_valid_o), 32'd0);

        // Stall fills the skid entry
        bus.ex_ready_i = 1'b0;
        drive(1'b1, 32'h20);
        tick();
        chk("stall_main_pc", bus.ex_pc_o, 32'h20);
        drive(1'b1, 32'h24);
        tick();
        drive(1'b0, 32'h0);
        chk("stall_ready",  32'(bus.id_ready_o), 32'd0);
        chk("stall_valid",  32'(bus.ex_valid_o), 32'd1);
        chk("stall_hold",   bus.ex_pc_o,         32'h20);
        tick();
        chk("stall_hold2",  bus.ex_pc_o,         32'h20);
        chk("stall_ready2", 32'(bus.id_ready_o), 32'd0);
        bus.ex_ready_i = 1'b1;
        tick();
        chk("unstall_pc",    bus.ex_pc_o,         32'h24);
        chk("unstall_valid", 32'(bus.ex_valid_o), 32'd1);
        chk("unstall_ready", 32'(bus.id_ready_o), 32'd1);
        tick();
        chk("unstall_empty", 32'(bus.ex_valid_o), 32'd0);

        // Flush while both entries are valid, with a same-cycle input
        bus.ex_ready_i  = 1'b0;
        bus.cu_reg_we_i = 1'b1;
        bus.cu_mem_we_i = 1'b1;
        drive(1'b1, 32'h40);
        tick();
        drive(1'b1, 32'h44);
        tick();
        chk("pre_flush_ready", 32'(bus.id_ready_o), 32'd0);
        chk("pre_flush_we",    32'(bus.ex_mem_we_o), 32'd1);
        bus.flush_i = 1'b1;
        drive(1'b1, 32'h30);
        tick();
        bus.flush_i = 1'b0;
        drive(1'b0, 32'h0);
        chk("flush_valid",  32'(bus.ex_valid_o),  32'd0);
        chk("flush_ready",  32'(bus.id_ready_o),  32'd1);
        chk("flush_reg_we", 32'(bus.ex_reg_we_o), 32'd0);
        chk("flush_mem_we", 32'(bus.ex_mem_we_o), 32'd0);
        chk("flush_no_pc30", 32'(bus.ex_pc_o == 32'h30), 32'd0);
        bus.ex_ready_i = 1'b1;
        tick();
        chk("flush_stays_empty", 32'(bus.ex_valid_o), 32'd0);
        chk("flush_no_pc30_b",   32'(bus.ex_pc_o == 32'h30), 32'd0);

        // Bubble: invalid input with enables driven high
        bus.cu_reg_we_i = 1'b1;
        bus.cu_mem_we_i = 1'b1;
        bus.cu_mem_re_i = 1'b1;
        drive(1'b0, 32'h50);
        tick();
        chk("bubble_valid",  32'(bus.ex_valid_o),  32'd0);
        chk("bubble_reg_we", 32'(bus.ex_reg_we_o), 32'd0);
        chk("bubble_mem_we", 32'(bus.ex_mem_we_o), 32'd0);
        chk("bubble_mem_re", 32'(bus.ex_mem_re_o), 32'd0);

        // Reset while both entries are valid
        bus.ex_ready_i    = 1'b0;
        bus.id_rs1_data_i = 32'h1234_5678;
        bus.id_imm_i      = 32'h0000_0ABC;
        bus.id_rd_addr_i  = 5'd31;
        bus.cu_ALUctrl_i  = ALU_XOR;
        bus.cu_wb_sel_i   = WB_PC4;
        drive(1'b1, 32'h60);
        tick();
        drive(1'b1, 32'h64);
        tick();
        drive(1'b0, 32'h0);
        chk("pre_rst_ready", 32'(bus.id_ready_o), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid",    32'(bus.ex_valid_o),    32'd0);
        chk("mrst_ready",    32'(bus.id_ready_o),    32'd1);
        chk("mrst_pc",       bus.ex_pc_o,            32'd0);
        chk("mrst_rs1_data", bus.ex_rs1_data_o,      32'd0);
        chk("mrst_rs2_data", bus.ex_rs2_data_o,      32'd0);
        chk("mrst_imm",      bus.ex_imm_o,           32'd0);
        chk("mrst_rd_addr",  32'(bus.ex_rd_addr_o),  32'd0);
        chk("mrst_rs1_addr", 32'(bus.ex_rs1_addr_o), 32'd0);
        chk("mrst_aluctrl",  32'(bus.ex_ALUctrl_o),  32'd0);
        chk("mrst_alu_src",  32'(bus.ex_alu_src_o),  32'd0);
        chk("mrst_reg_we",   32'(bus.ex_reg_we_o),   32'd0);
        chk("mrst_mem_re",   32'(bus.ex_mem_re_o),   32'd0);
        chk("mrst_mem_we",   32'(bus.ex_mem_we_o),   32'd0);
        chk("mrst_wb_sel",   32'(bus.ex_wb_sel_o),   32'd0);

        // After reset, a fresh instruction is taken normally
        bus.ex_ready_i = 1'b1;
        drive(1'b1, 32'h70);
        tick();
        drive(1'b0, 32'h0);
        chk("post_rst_pc",       bus.ex_pc_o,           32'h70);
        chk("post_rst_valid",    32'(bus.ex_valid_o),   32'd1);
        chk("post_rst_wb_sel",   32'(bus.ex_wb_sel_o),  32'd2);
        chk("post_rst_aluctrl",  32'(bus.ex_ALUctrl_o), 32'd4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
